// File: rtl/mips_io_top.sv
// mips_io_top: lab-board I/O block. R captures two 8-bit operands from the
// slide switches, L latches their 9-bit sum, and operands plus result are
// scanned continuously onto an 8-digit multiplexed seven-segment display.
module mips_io_top #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        L,
    input  logic        R,
    input  logic [15:0] SW,
    output logic [7:0]  AN,
    output logic        DP,
    output logic [6:0]  A2G
);

    localparam logic [SCAN_BITS-1:0] CNT_ONE = 1;

    logic                 l_s1, l_s2, l_s3;
    logic                 r_s1, r_s2, r_s3;
    logic                 l_pulse, r_pulse;
    logic [7:0]           opa, opb;
    logic [8:0]           result;
    logic [SCAN_BITS-1:0] cnt;
    logic [2:0]           sel;
    logic [3:0]           digit;

    // Two-flop synchronizers plus a delay stage for edge detection; the
    // first stage only takes a clean 1, so X/Z on a button reads as released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_s1 <= 1'b0;
            l_s2 <= 1'b0;
            l_s3 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            l_s1 <= (L === 1'b1);
            l_s2 <= l_s1;
            l_s3 <= l_s2;
            r_s1 <= (R === 1'b1);
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign l_pulse = l_s2 & ~l_s3;
    assign r_pulse = r_s2 & ~r_s3;

    // Operand capture and sum; a simultaneous R/L adds the operands held
    // before this edge because both updates are non-blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            result <= '0;
        end else begin
            if (r_pulse) begin
                opa <= SW[15:8];
                opb <= SW[7:0];
            end
            if (l_pulse) begin
                result <= {1'b0, opa} + {1'b0, opb};
            end
        end
    end

    // Free-running refresh counter; its top three bits pick the digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign sel = cnt[SCAN_BITS-1 -: 3];
    assign DP  = 1'b1;

    // Digit source select and anode drive from the same select value.
    always_comb begin
        digit = 4'h0;
        case (sel)
            3'd7: digit = opa[7:4];
            3'd6: digit = opa[3:0];
            3'd5: digit = opb[7:4];
            3'd4: digit = opb[3:0];
            3'd3: digit = 4'h0;
            3'd2: digit = {3'b000, result[8]};
            3'd1: digit = result[7:4];
            3'd0: digit = result[3:0];
            default: digit = 4'h0;
        endcase
        AN = ~(8'b0000_0001 << sel);
    end

    // Hex to active-low abcdefg segment decode.
    always_comb begin
        A2G = 7'b1111111;
        case (digit)
            4'h0: A2G = 7'b0000001;
            4'h1: A2G = 7'b1001111;
            4'h2: A2G = 7'b0010010;
            4'h3: A2G = 7'b0000110;
            4'h4: A2G = 7'b1001100;
            4'h5: A2G = 7'b0100100;
            4'h6: A2G = 7'b0100000;
            4'h7: A2G = 7'b0001111;
            4'h8: A2G = 7'b0000000;
            4'h9: A2G = 7'b0000100;
            4'hA: A2G = 7'b0001000;
            4'hB: A2G = 7'b1100000;
            4'hC: A2G = 7'b0110001;
            4'hD: A2G = 7'b1000010;
            4'hE: A2G = 7'b0110000;
            4'hF: A2G = 7'b0111000;
            default: A2G = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_mips_io_top.sv
// tb_mips_io_top: directed bench for mips_io_top with a short refresh
// counter so every digit comes round within 16 clocks.
`timescale 1ns/100ps
module tb_mips_io_top;

    logic        clk;
    logic        reset;
    logic        L;
    logic        R;
    logic [15:0] SW;
    logic [7:0]  AN;
    logic        DP;
    logic [6:0]  A2G;

    int n_tests;
    int n_fail;

    mips_io_top #(.SCAN_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .L     (L),
        .R     (R),
        .SW    (SW),
        .AN    (AN),
        .DP    (DP),
        .A2G   (A2G)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Wait (bounded) until the anode for digit s is active, return its segments.
    task automatic read_digit(input int s, output logic [6:0] seg, output bit found);
        logic [7:0] want;
        want  = ~(8'b0000_0001 << s);
        found = 1'b0;
        seg   = 7'bxxxxxxx;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (AN === want) begin
                found = 1'b1;
                seg   = A2G;
            end
        end
    endtask

    task automatic press(input logic r, input logic l, input int hold);
        @(negedge clk);
        R = r;
        L = l;
        repeat (hold) @(negedge clk);
        R = 1'b0;
        L = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [6:0] seg;
        bit         found;
        reset = 1'b1;
        SW    = 16'h1234;
        #50;
        n_tests++;
        if (AN !== 8'hFE) begin
            n_fail++;
            $display("FAIL reset_an: got %h want fe", AN);
        end
        n_tests++;
        if (A2G !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_a2g: got %b want 0000001", A2G);
        end
        n_tests++;
        if (DP !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dp: got %b want 1", DP);
        end
        n_tests++;
        if (dut.opa !== 8'h00 || dut.opb !== 8'h00 || dut.result !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_regs: got opa=%h opb=%h result=%h want 0/0/0",
                     dut.opa, dut.opb, dut.result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            read_digit(s, seg, found);
            n_tests++;
            if (!found || seg !== 7'b0000001) begin
                n_fail++;
                $display("FAIL reset_digit%0d: found=%0d got %b want 0000001", s, found, seg);
            end
        end
    endtask

    task automatic test_capture;
        @(negedge clk);
        SW = 16'h1234;
        R  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #0.5;
        n_tests++;
        if (dut.opa !== 8'h00) begin
            n_fail++;
            $display("FAIL capture_early: got opa=%h want 00 after 2 edges", dut.opa);
        end
        @(posedge clk);
        #0.5;
        n_tests++;
        if (dut.opa !== 8'h12 || dut.opb !== 8'h34) begin
            n_fail++;
            $display("FAIL capture_3rd_edge: got opa=%h opb=%h want 12/34", dut.opa, dut.opb);
        end
        // Switches move while R is still held: no second load may happen.
        @(negedge clk);
        SW = 16'h5678;
        repeat (20) @(negedge clk);
        R = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (dut.opa !== 8'h12 || dut.opb !== 8'h34 || dut.result !== 9'h000) begin
            n_fail++;
            $display("FAIL capture_single: got opa=%h opb=%h result=%h want 12/34/000",
                     dut.opa, dut.opb, dut.result);
        end
    endtask

    task automatic test_sum;
        logic [3:0] exp_d [8];
        logic [6:0] seg;
        bit         found;
        exp_d[7] = 4'h1; exp_d[6] = 4'h2; exp_d[5] = 4'h3; exp_d[4] = 4'h4;
        exp_d[3] = 4'h0; exp_d[2] = 4'h0; exp_d[1] = 4'h4; exp_d[0] = 4'h6;
        #200;
        @(negedge clk);
        L = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #0.5;
        n_tests++;
        if (dut.result !== 9'h000) begin
            n_fail++;
            $display("FAIL sum_early: got result=%h want 000 after 2 edges", dut.result);
        end
        @(posedge clk);
        #0.5;
        n_tests++;
        if (dut.result !== 9'h046) begin
            n_fail++;
            $display("FAIL sum_3rd_edge: got result=%h want 046", dut.result);
        end
        repeat (24) @(negedge clk);
        L = 1'b0;
        for (int s = 7; s >= 0; s--) begin
            read_digit(s, seg, found);
            n_tests++;
            if (!found || seg !== hex7(exp_d[s])) begin
                n_fail++;
                $display("FAIL sum_digit%0d: found=%0d got %b want %b",
                         s, found, seg, hex7(exp_d[s]));
            end
        end
        read_digit(0, seg, found);
        n_tests++;
        if (!found || seg !== 7'b0100000) begin
            n_fail++;
            $display("FAIL sum_sel0_seg: found=%0d got %b want 0100000", found, seg);
        end
    endtask

    task automatic test_carry;
        logic [6:0] seg;
        bit         found;
        SW = 16'hFFFF;
        press(1'b1, 1'b0, 5);
        press(1'b0, 1'b1, 5);
        n_tests++;
        if (dut.result !== 9'h1FE) begin
            n_fail++;
            $display("FAIL carry_result: got %h want 1fe", dut.result);
        end
        read_digit(2, seg, found);
        n_tests++;
        if (!found || seg !== 7'b1001111) begin
            n_fail++;
            $display("FAIL carry_sel2: found=%0d got %b want 1001111", found, seg);
        end
        read_digit(1, seg, found);
        n_tests++;
        if (!found || seg !== 7'b0111000) begin
            n_fail++;
            $display("FAIL carry_sel1: found=%0d got %b want 0111000", found, seg);
        end
        read_digit(0, seg, found);
        n_tests++;
        if (!found || seg !== 7'b0110000) begin
            n_fail++;
            $display("FAIL carry_sel0: found=%0d got %b want 0110000", found, seg);
        end
    endtask

    task automatic test_noload_simul;
        SW = 16'hABCD;
        repeat (10) @(negedge clk);
        n_tests++;
        if (dut.opa !== 8'hFF || dut.opb !== 8'hFF) begin
            n_fail++;
            $display("FAIL noload_ops: got opa=%h opb=%h want ff/ff", dut.opa, dut.opb);
        end
        press(1'b0, 1'b1, 5);
        n_tests++;
        if (dut.result !== 9'h1FE) begin
            n_fail++;
            $display("FAIL noload_result: got %h want 1fe", dut.result);
        end
        SW = 16'h1234;
        press(1'b1, 1'b0, 5);
        n_tests++;
        if (dut.opa !== 8'h12 || dut.opb !== 8'h34 || dut.result !== 9'h1FE) begin
            n_fail++;
            $display("FAIL reload: got opa=%h opb=%h result=%h want 12/34/1fe",
                     dut.opa, dut.opb, dut.result);
        end
        SW = 16'hABCD;
        press(1'b1, 1'b1, 5);
        n_tests++;
        if (dut.opa !== 8'hAB || dut.opb !== 8'hCD) begin
            n_fail++;
            $display("FAIL simul_ops: got opa=%h opb=%h want ab/cd", dut.opa, dut.opb);
        end
        n_tests++;
        if (dut.result !== 9'h046) begin
            n_fail++;
            $display("FAIL simul_result: got %h want 046", dut.result);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #0.5;
        reset = 1'b1;
        #0.2;
        n_tests++;
        if (dut.opa !== 8'h00 || dut.opb !== 8'h00 || dut.result !== 9'h000) begin
            n_fail++;
            $display("FAIL async_regs: got opa=%h opb=%h result=%h want 0/0/0",
                     dut.opa, dut.opb, dut.result);
        end
        n_tests++;
        if (AN !== 8'hFE || A2G !== 7'b0000001) begin
            n_fail++;
            $display("FAIL async_display: got AN=%h A2G=%b want fe/0000001", AN, A2G);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #0.1;
        n_tests++;
        if (AN !== 8'hFE) begin
            n_fail++;
            $display("FAIL async_release_an: got %h want fe", AN);
        end
        @(posedge clk);
        @(posedge clk);
        #0.5;
        n_tests++;
        if (AN !== 8'hFD) begin
            n_fail++;
            $display("FAIL async_scan_resume: got %h want fd", AN);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        L       = 1'b0;
        R       = 1'b0;
        SW      = 16'h0000;
        test_reset();
        test_capture();
        test_sum();
        test_carry();
        test_noload_simul();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
